// File: rtl/elbeth_mem_wb.sv
// Memory/write-back stage of the ELBETH RV32I pipeline: data-memory bus handshake,
// load alignment/extension and register-file write port. Option: ELBETH_MEM_MISALIGN_TRAP_EN.
module elbeth_mem_wb (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic [31:0] ex_alu_result,
   input  logic [31:0] ex_store_data,
   input  logic [4:0]  ex_rd_addr,
   input  logic        ex_reg_w_en,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic [1:0]  ex_mem_size,
   input  logic        ex_mem_unsigned,
   output logic        mem_stall,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wsel,
   output logic        dmem_wr,
   output logic        dmem_valid,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ready,
   output logic [31:0] wb_rd_data,
   output logic [4:0]  wb_rd_addr,
   output logic        wb_w_en
`ifdef ELBETH_MEM_MISALIGN_TRAP_EN
   ,
   output logic        mem_xcpt_misaligned
`endif
);

   // state   | meaning
   // ST_IDLE | accepting instructions from EX
   // ST_BUS  | bus request outstanding, waiting for dmem_ready
   typedef enum logic {ST_IDLE, ST_BUS} state_t;

   state_t      state_q, state_nx;
   logic        is_mem;
   logic        trap_hit;
   logic        accept_alu;
   logic        accept_mem;
   logic        bus_done;
   logic [31:0] st_wdata;
   logic [3:0]  st_wsel;
   logic [1:0]  lat_off;
   logic [1:0]  lat_size;
   logic        lat_uns;
   logic [4:0]  lat_rd;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;

   assign is_mem = ex_mem_read | ex_mem_write;

`ifdef ELBETH_MEM_MISALIGN_TRAP_EN
   logic misaligned;
   assign misaligned = ((ex_mem_size == 2'b01) & ex_alu_result[0]) |
                       (ex_mem_size[1] & (|ex_alu_result[1:0]));
   assign trap_hit   = (state_q == ST_IDLE) & ex_valid & is_mem & misaligned;
`else
   assign trap_hit   = 1'b0;
`endif

   assign accept_alu = (state_q == ST_IDLE) & ex_valid & ~is_mem;
   assign accept_mem = (state_q == ST_IDLE) & ex_valid & is_mem & ~trap_hit;
   assign bus_done   = (state_q == ST_BUS) & dmem_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_nx;
   end

   // Stall is forced low during reset so an abandoned access releases EX at once.
   always_comb begin
      state_nx  = state_q;
      mem_stall = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept_mem) begin
               state_nx  = ST_BUS;
               mem_stall = 1'b1;
            end
         end
         ST_BUS: begin
            mem_stall = ~dmem_ready;
            if (dmem_ready) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
      if (rst) mem_stall = 1'b0;
   end

   always_comb begin
      st_wdata = ex_store_data;
      st_wsel  = 4'b1111;
      case (ex_mem_size)
         2'b00: begin
            st_wdata = {4{ex_store_data[7:0]}};
            st_wsel  = 4'b0001 << ex_alu_result[1:0];
         end
         2'b01: begin
            st_wdata = {2{ex_store_data[15:0]}};
            st_wsel  = 4'b0011 << {ex_alu_result[1], 1'b0};
         end
         default: ;
      endcase
   end

   always_comb begin
      case (lat_off)
         2'd0:    ld_byte = dmem_rdata[7:0];
         2'd1:    ld_byte = dmem_rdata[15:8];
         2'd2:    ld_byte = dmem_rdata[23:16];
         default: ld_byte = dmem_rdata[31:24];
      endcase
      ld_half = lat_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (lat_size)
         2'b00:   ld_data = {{24{~lat_uns & ld_byte[7]}}, ld_byte};
         2'b01:   ld_data = {{16{~lat_uns & ld_half[15]}}, ld_half};
         default: ld_data = dmem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         dmem_wsel  <= '0;
         dmem_wr    <= 1'b0;
         dmem_valid <= 1'b0;
         lat_off    <= '0;
         lat_size   <= '0;
         lat_uns    <= 1'b0;
         lat_rd     <= '0;
         wb_rd_data <= '0;
         wb_rd_addr <= '0;
         wb_w_en    <= 1'b0;
      end else begin
         wb_w_en <= 1'b0;
         if (accept_alu) begin
            wb_rd_data <= ex_alu_result;
            wb_rd_addr <= ex_rd_addr;
            wb_w_en    <= ex_reg_w_en & (|ex_rd_addr);
         end
         if (accept_mem) begin
            dmem_addr  <= {ex_alu_result[31:2], 2'b00};
            dmem_wr    <= ex_mem_write;
            dmem_valid <= 1'b1;
            dmem_wdata <= ex_mem_write ? st_wdata : 32'd0;
            dmem_wsel  <= ex_mem_write ? st_wsel : 4'd0;
            lat_off    <= ex_alu_result[1:0];
            lat_size   <= ex_mem_size;
            lat_uns    <= ex_mem_unsigned;
            lat_rd     <= ex_rd_addr;
         end
         if (bus_done) begin
            dmem_valid <= 1'b0;
            dmem_wr    <= 1'b0;
            dmem_wsel  <= 4'd0;
            if (!dmem_wr) begin
               wb_rd_data <= ld_data;
               wb_rd_addr <= lat_rd;
               wb_w_en    <= |lat_rd;
            end
         end
      end
   end

`ifdef ELBETH_MEM_MISALIGN_TRAP_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) mem_xcpt_misaligned <= 1'b0;
      else     mem_xcpt_misaligned <= trap_hit;
   end
`endif

endmodule

// File: tb/tb_elbeth_mem_wb.sv
// Self-checking bench for elbeth_mem_wb: randomized ALU, load and store traffic
// against an arithmetic reference of the alignment/extension rules.
module tb_elbeth_mem_wb;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid;
   logic [31:0] ex_alu_result;
   logic [31:0] ex_store_data;
   logic [4:0]  ex_rd_addr;
   logic        ex_reg_w_en;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic [1:0]  ex_mem_size;
   logic        ex_mem_unsigned;
   logic        mem_stall;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wsel;
   logic        dmem_wr;
   logic        dmem_valid;
   logic [31:0] dmem_rdata;
   logic        dmem_ready;
   logic [31:0] wb_rd_data;
   logic [4:0]  wb_rd_addr;
   logic        wb_w_en;
`ifdef ELBETH_MEM_MISALIGN_TRAP_EN
   logic        mem_xcpt_misaligned;
`endif

   int total = 0;
   int bad   = 0;

   elbeth_mem_wb dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
      .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr), .ex_reg_w_en(ex_reg_w_en),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_size(ex_mem_size),
      .ex_mem_unsigned(ex_mem_unsigned), .mem_stall(mem_stall), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_wsel(dmem_wsel), .dmem_wr(dmem_wr),
      .dmem_valid(dmem_valid), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
      .wb_rd_data(wb_rd_data), .wb_rd_addr(wb_rd_addr), .wb_w_en(wb_w_en)
`ifdef ELBETH_MEM_MISALIGN_TRAP_EN
      , .mem_xcpt_misaligned(mem_xcpt_misaligned)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] addr,
                                            input logic [1:0] size, input logic uns);
      logic [31:0] v;
      if (size == 2'b00) begin
         v = (rdata >> ((addr % 4) * 8)) & 32'hFF;
         if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end else if (size == 2'b01) begin
         v = (rdata >> (((addr / 2) % 2) * 16)) & 32'hFFFF;
         if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end else begin
         v = rdata;
      end
      return v;
   endfunction

   function automatic logic [3:0] ref_wsel(input logic [31:0] addr, input logic [1:0] size);
      if (size == 2'b00) return 4'(1 << (addr % 4));
      if (size == 2'b01) return 4'(3 << (((addr / 2) % 2) * 2));
      return 4'hF;
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [31:0] d, input logic [1:0] size);
      if (size == 2'b00) return (d & 32'hFF) * 32'h0101_0101;
      if (size == 2'b01) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   task automatic idle_inputs();
      ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
      ex_reg_w_en = 1'b0; dmem_ready = 1'b0;
   endtask

   task automatic alu_op(input logic [31:0] res, input logic [4:0] rd, input logic wen,
                         input logic noise);
      logic exp_w;
      @(negedge clk);
      ex_valid = 1'b1; ex_alu_result = res; ex_rd_addr = rd; ex_reg_w_en = wen;
      ex_mem_read = 1'b0; ex_mem_write = 1'b0; dmem_ready = noise;
      ex_store_data = $urandom; dmem_rdata = $urandom;
      #1;
      total++;
      if (mem_stall !== 1'b0) begin bad++; $display("FAIL alu_stall got=%b want=0", mem_stall); end
      exp_w = wen && (rd != 5'd0);
      @(negedge clk);
      idle_inputs();
      total++;
      if (wb_w_en !== exp_w || dmem_valid !== 1'b0) begin
         bad++; $display("FAIL alu_wen got=%b/%b want=%b/0", wb_w_en, dmem_valid, exp_w);
      end
      if (exp_w) begin
         total++;
         if (wb_rd_data !== res || wb_rd_addr !== rd) begin
            bad++; $display("FAIL alu_data got=%h/%0d want=%h/%0d", wb_rd_data, wb_rd_addr, res, rd);
         end
      end
      @(negedge clk);
      total++;
      if (wb_w_en !== 1'b0) begin bad++; $display("FAIL alu_pulse got=%b want=0", wb_w_en); end
   endtask

   task automatic mem_op(input logic [31:0] addr, input logic [31:0] sdata, input logic [1:0] size,
                         input logic uns, input logic [4:0] rd, input logic rdf, input logic wrf,
                         input int waits, input logic [31:0] rdata);
      int stalls;
      logic exp_w;
      logic [31:0] exp_d;
      stalls = 0;
      @(negedge clk);
      ex_valid = 1'b1; ex_alu_result = addr; ex_store_data = sdata; ex_mem_size = size;
      ex_mem_unsigned = uns; ex_rd_addr = rd; ex_reg_w_en = rdf & ~wrf;
      ex_mem_read = rdf; ex_mem_write = wrf; dmem_ready = 1'b0;
      #1;
      total++;
      if (mem_stall !== 1'b1) begin bad++; $display("FAIL mem_accept_stall got=%b want=1", mem_stall); end
      else stalls++;
      @(negedge clk);
      total++;
      if (dmem_valid !== 1'b1 || dmem_addr !== (addr & 32'hFFFF_FFFC) || dmem_wr !== wrf) begin
         bad++;
         $display("FAIL mem_req got=%b/%h/%b want=1/%h/%b", dmem_valid, dmem_addr, dmem_wr,
                  addr & 32'hFFFF_FFFC, wrf);
      end
      if (wrf) begin
         total++;
         if (dmem_wsel !== ref_wsel(addr, size) || dmem_wdata !== ref_wdata(sdata, size)) begin
            bad++;
            $display("FAIL store_enc got=%b/%h want=%b/%h", dmem_wsel, dmem_wdata,
                     ref_wsel(addr, size), ref_wdata(sdata, size));
         end
      end
      for (int i = 0; i < waits; i++) begin
         total++;
         if (mem_stall !== 1'b1 || dmem_valid !== 1'b1 || dmem_addr !== (addr & 32'hFFFF_FFFC)) begin
            bad++; $display("FAIL mem_wait got=%b/%b/%h want=1/1", mem_stall, dmem_valid, dmem_addr);
         end else stalls++;
         @(negedge clk);
      end
      dmem_ready = 1'b1; dmem_rdata = rdata;
      #1;
      total++;
      if (mem_stall !== 1'b0) begin bad++; $display("FAIL mem_ready_stall got=%b want=0", mem_stall); end
      total++;
      if (stalls != waits + 1) begin bad++; $display("FAIL stall_cycles got=%0d want=%0d", stalls, waits + 1); end
      exp_w = !wrf && (rd != 5'd0);
      exp_d = ref_load(rdata, addr, size, uns);
      @(negedge clk);
      idle_inputs();
      dmem_rdata = $urandom;
      total++;
      if (wb_w_en !== exp_w || dmem_valid !== 1'b0) begin
         bad++; $display("FAIL mem_wb got=%b/%b want=%b/0", wb_w_en, dmem_valid, exp_w);
      end
      if (exp_w) begin
         total++;
         if (wb_rd_data !== exp_d || wb_rd_addr !== rd) begin
            bad++; $display("FAIL load_data got=%h/%0d want=%h/%0d", wb_rd_data, wb_rd_addr, exp_d, rd);
         end
      end
      @(negedge clk);
      total++;
      if (wb_w_en !== 1'b0 || mem_stall !== 1'b0) begin
         bad++; $display("FAIL mem_after got=%b/%b want=0/0", wb_w_en, mem_stall);
      end
   endtask

   function automatic logic [31:0] legal_addr(input logic [31:0] a, input logic [1:0] size);
`ifdef ELBETH_MEM_MISALIGN_TRAP_EN
      if (size == 2'b01) return a & 32'hFFFF_FFFE;
      if (size[1])       return a & 32'hFFFF_FFFC;
`endif
      return a;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      ex_alu_result = '0; ex_store_data = '0; ex_rd_addr = '0; ex_mem_size = '0;
      ex_mem_unsigned = 1'b0; dmem_rdata = '0;
      @(negedge clk);
      total++;
      if (mem_stall !== 0 || dmem_valid !== 0 || dmem_wr !== 0 || dmem_addr !== 0 ||
          dmem_wsel !== 0 || dmem_wdata !== 0 || wb_w_en !== 0 || wb_rd_data !== 0 || wb_rd_addr !== 0) begin
         bad++; $display("FAIL reset_state got=%b%b%b%b %h", mem_stall, dmem_valid, dmem_wr, wb_w_en, wb_rd_data);
      end
      rst = 1'b0;
   endtask

   task automatic test_alu();
      alu_op(32'h1234_5678, 5'd5, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++)
         alu_op($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0), 1'($urandom));
   endtask

   task automatic test_load();
      mem_op(32'h0000_0103, 32'h0, 2'b00, 1'b0, 5'd7, 1'b1, 1'b0, 0, 32'h80FF_0000);
      mem_op(32'h0000_0103, 32'h0, 2'b00, 1'b1, 5'd7, 1'b1, 1'b0, 0, 32'h80FF_0000);
      mem_op(32'h0000_0400, 32'h0, 2'b10, 1'b0, 5'd9, 1'b1, 1'b0, 3, 32'hCAFE_F00D);
      for (int i = 0; i < 16; i++) begin
         logic [1:0] sz;
         sz = 2'($urandom);
         mem_op(legal_addr($urandom, sz), $urandom, sz, 1'($urandom), 5'($urandom_range(1, 31)),
                1'b1, 1'b0, $urandom_range(0, 3), $urandom);
      end
   endtask

   task automatic test_store();
      mem_op(32'h0000_0202, 32'h0000_BEEF, 2'b01, 1'b0, 5'd3, 1'b0, 1'b1, 0, 32'h0);
      mem_op(32'h0000_0301, 32'hAABB_CCDD, 2'b00, 1'b0, 5'd4, 1'b1, 1'b1, 1, $urandom);
      for (int i = 0; i < 12; i++) begin
         logic [1:0] sz;
         sz = 2'($urandom);
         mem_op(legal_addr($urandom, sz), $urandom, sz, 1'($urandom), 5'($urandom),
                1'($urandom), 1'b1, $urandom_range(0, 2), $urandom);
      end
   endtask

   task automatic test_rd0();
      mem_op(32'h0000_0010, 32'h0, 2'b10, 1'b0, 5'd0, 1'b1, 1'b0, 1, 32'hFFFF_FFFF);
      alu_op(32'hDEAD_BEEF, 5'd0, 1'b1, 1'b0);
   endtask

   task automatic test_idle();
      @(negedge clk);
      ex_valid = 1'b0; ex_mem_read = 1'b1; ex_reg_w_en = 1'b1; ex_rd_addr = 5'd8;
      dmem_ready = 1'b1;
      #1;
      total++;
      if (mem_stall !== 1'b0) begin bad++; $display("FAIL idle_stall got=%b want=0", mem_stall); end
      @(negedge clk);
      total++;
      if (wb_w_en !== 1'b0 || dmem_valid !== 1'b0) begin
         bad++; $display("FAIL idle_wb got=%b/%b want=0/0", wb_w_en, dmem_valid);
      end
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      logic [31:0] r1, r2;
      r1 = $urandom; r2 = $urandom;
      @(negedge clk);
      ex_valid = 1'b1; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_w_en = 1'b1;
      ex_alu_result = r1; ex_rd_addr = 5'd11;
      @(negedge clk);
      ex_alu_result = r2; ex_rd_addr = 5'd12;
      total++;
      if (wb_w_en !== 1'b1 || wb_rd_data !== r1 || wb_rd_addr !== 5'd11) begin
         bad++; $display("FAIL b2b_first got=%b/%h want=1/%h", wb_w_en, wb_rd_data, r1);
      end
      @(negedge clk);
      idle_inputs();
      total++;
      if (wb_w_en !== 1'b1 || wb_rd_data !== r2 || wb_rd_addr !== 5'd12) begin
         bad++; $display("FAIL b2b_second got=%b/%h want=1/%h", wb_w_en, wb_rd_data, r2);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      ex_valid = 1'b1; ex_alu_result = 32'h0000_0800; ex_mem_size = 2'b10; ex_rd_addr = 5'd6;
      ex_reg_w_en = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; dmem_ready = 1'b0;
      @(negedge clk);
      total++;
      if (dmem_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b want=1", dmem_valid); end
      rst = 1'b1;
      #1;
      total++;
      if (dmem_valid !== 1'b0 || mem_stall !== 1'b0 || wb_w_en !== 1'b0) begin
         bad++; $display("FAIL rstmid_drop got=%b/%b/%b want=0/0/0", dmem_valid, mem_stall, wb_w_en);
      end
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
      alu_op(32'h0BAD_F00D, 5'd21, 1'b1, 1'b0);
   endtask

`ifdef ELBETH_MEM_MISALIGN_TRAP_EN
   task automatic test_misaligned();
      @(negedge clk);
      ex_valid = 1'b1; ex_alu_result = 32'h0000_0002; ex_mem_size = 2'b10; ex_rd_addr = 5'd2;
      ex_reg_w_en = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
      #1;
      total++;
      if (mem_stall !== 1'b0) begin bad++; $display("FAIL mis_stall got=%b want=0", mem_stall); end
      @(negedge clk);
      idle_inputs();
      total++;
      if (mem_xcpt_misaligned !== 1'b1 || dmem_valid !== 1'b0 || wb_w_en !== 1'b0) begin
         bad++; $display("FAIL mis_pulse got=%b/%b/%b want=1/0/0", mem_xcpt_misaligned, dmem_valid, wb_w_en);
      end
      @(negedge clk);
      total++;
      if (mem_xcpt_misaligned !== 1'b0) begin bad++; $display("FAIL mis_end got=%b want=0", mem_xcpt_misaligned); end
   endtask
`endif

   initial begin
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_rd0();
      test_idle();
      test_back_to_back();
      test_reset_mid();
`ifdef ELBETH_MEM_MISALIGN_TRAP_EN
      test_misaligned();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
